// File: rtl/mmio_uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package mmio_uart_pkg;

  // Word offsets within the register window (aluoutM[3:2])
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  // STATUS bit positions
  localparam int ST_BUSY    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_FULL    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  // CTRL bit positions
  localparam int CT_EN    = 0;
  localparam int CT_IRQEN = 1;
  localparam int CT_ODD   = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two so the
// pointers wrap naturally. Caller guarantees push only when !full or popping.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;

  // Storage array; no reset needed, validity tracked by count
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the M-stage store/load port.
// Optional build macro UART_TX_PARITY_EN adds a parity bit (CTRL[2] = odd).
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwriteM,
  input  logic        sbM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
  localparam tx_state_t AFTER_DATA = PARITY;
`else
  localparam tx_state_t AFTER_DATA = STOP;
`endif

  logic [1:0]    off;
  logic          wr, push_req, push, pop;
  logic          full, empty;
  logic [CW-1:0] count;
  logic [7:0]    fifo_q;
  tx_state_t     state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    data, data_n;
  logic          en, irqen, odd, ovf;
  logic          busy, bit_done, par;
  logic          unused_bits;

  // Byte-store qualifier and non-register bits carry no meaning here
  assign unused_bits = ^{sbM, writedataM[31:8], aluoutM[1:0]};

  assign sel      = (aluoutM[31:4] == BASE_ADDR[31:4]);
  assign off      = aluoutM[3:2];
  assign wr       = sel & memwriteM;
  assign push_req = wr & (off == OFF_TXDATA);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  assign push     = push_req & (~full | pop);
  assign busy     = (state != IDLE);
  assign bit_done = (baud == BAUD_LAST);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .wdata (writedataM[7:0]),
    .rdata (fifo_q),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Control register and sticky overflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en    <= 1'b0;
      irqen <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (wr && off == OFF_CTRL) begin
        en    <= writedataM[CT_EN];
        irqen <= writedataM[CT_IRQEN];
      end
      if (push_req && !push)                ovf <= 1'b1;
      else if (wr && off == OFF_STATUS)     ovf <= 1'b0;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity sense select
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       odd <= 1'b0;
    else if (wr && off == OFF_CTRL)   odd <= writedataM[CT_ODD];
  end
  assign par = odd ? ~^data : ^data;
`else
  assign odd = 1'b0;
  assign par = 1'b1;
`endif

  // Level interrupt: idle with nothing left to send
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq <= 1'b0;
    else        irq <= irqen & empty & ~busy;
  end

  // FSM and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      baud  <= '0;
      idx   <= '0;
      data  <= '0;
    end else begin
      state <= state_n;
      baud  <= baud_n;
      idx   <= idx_n;
      data  <= data_n;
    end
  end

  // Next-state: each serial bit lasts CLKS_PER_BIT cycles; STOP can chain
  // straight into START so queued bytes go out with no idle gap
  always_comb begin
    state_n = state;
    baud_n  = baud;
    idx_n   = idx;
    data_n  = data;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (en && !empty) begin
          pop     = 1'b1;
          data_n  = fifo_q;
          state_n = START;
        end
      end
      START: begin
        if (bit_done) begin
          baud_n  = '0;
          idx_n   = '0;
          state_n = DATA;
        end else baud_n = baud + 1'b1;
      end
      DATA: begin
        if (bit_done) begin
          baud_n = '0;
          idx_n  = idx + 1'b1;
          if (idx == 3'd7) state_n = AFTER_DATA;
        end else baud_n = baud + 1'b1;
      end
      PARITY: begin
        if (bit_done) begin
          baud_n  = '0;
          state_n = STOP;
        end else baud_n = baud + 1'b1;
      end
      STOP: begin
        if (bit_done) begin
          baud_n = '0;
          if (en && !empty) begin
            pop     = 1'b1;
            data_n  = fifo_q;
            state_n = START;
          end else state_n = IDLE;
        end else baud_n = baud + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Serial line decode from registered state; idle/stop high
  always_comb begin
    txd = 1'b1;
    case (state)
      START:   txd = 1'b0;
      DATA:    txd = data[idx];
      PARITY:  txd = par;
      default: txd = 1'b1;
    endcase
  end

  // Register read mux
  always_comb begin
    rdata = '0;
    case (off)
      OFF_STATUS: begin
        rdata[ST_BUSY]            = busy;
        rdata[ST_EMPTY]           = empty;
        rdata[ST_FULL]            = full;
        rdata[ST_OVF]             = ovf;
        rdata[ST_CNT_LSB +: 8]    = 8'(count);
      end
      OFF_CTRL: begin
        rdata[CT_EN]    = en;
        rdata[CT_IRQEN] = irqen;
        rdata[CT_ODD]   = odd;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized bench for mmio_uart_tx against a frame-position reference model.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'hFFFF_FF00;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR   = 1'b0;
`endif
  localparam int FL = NBITS * CPB;

  logic        clk = 1'b0;
  logic        reset, memwriteM, sbM;
  logic [31:0] aluoutM, writedataM, rdata;
  logic        sel, txd, irq;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .memwriteM  (memwriteM),
    .sbM        (sbM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .sel        (sel),
    .rdata      (rdata),
    .txd        (txd),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model: queued bytes plus position (in cycles) within the frame
  logic [7:0] q[$];
  int         pos;
  logic [7:0] cur;
  bit         m_en, m_irqen, m_odd, m_ovf, m_irq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pos = -1; cur = '0;
    m_en = 0; m_irqen = 0; m_odd = 0; m_ovf = 0; m_irq = 0;
  endtask

  function automatic logic [31:0] m_reg(input logic [1:0] o);
    logic [31:0] r;
    r = '0;
    if (o == 2'd1) begin
      r[0]    = (pos >= 0);
      r[1]    = (q.size() == 0);
      r[2]    = (q.size() == DEPTH);
      r[3]    = m_ovf;
      r[15:8] = 8'(q.size());
    end else if (o == 2'd2) begin
      r[0] = m_en; r[1] = m_irqen; r[2] = m_odd;
    end
    return r;
  endfunction

  function automatic logic m_txd();
    int b;
    if (pos < 0) return 1'b1;
    b = pos / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur[b-1];
    if (PAR && b == 9) return (^cur) ^ m_odd;
    return 1'b1;
  endfunction

  // One clock: check combinational outputs, advance model with pre-edge inputs
  task automatic step();
    bit inwin, wr, pop, full0, n_irq;
    logic [1:0]  o;
    logic [31:0] wd;
    #1;
    inwin = (aluoutM[31:4] == BASE[31:4]);
    chk("sel", {31'b0, sel}, {31'b0, inwin});
    if (inwin) chk("rdata", rdata, m_reg(aluoutM[3:2]));
    wr    = inwin && memwriteM;
    o     = aluoutM[3:2];
    wd    = writedataM;
    full0 = (q.size() == DEPTH);
    pop   = m_en && q.size() != 0 && (pos < 0 || pos == FL - 1);
    n_irq = m_irqen && q.size() == 0 && pos < 0;
    @(posedge clk); #1;
    if (pos >= 0 && pos < FL - 1) pos++;
    else pos = pop ? 0 : -1;
    if (pop) cur = q.pop_front();
    if (wr) begin
      case (o)
        2'd0: if (!full0 || pop) q.push_back(wd[7:0]); else m_ovf = 1;
        2'd1: m_ovf = 0;
        2'd2: begin m_en = wd[0]; m_irqen = wd[1]; m_odd = PAR ? wd[2] : 1'b0; end
        default: ;
      endcase
    end
    m_irq = n_irq;
    chk("txd", {31'b0, txd}, {31'b0, m_txd()});
    chk("irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic wr(input logic [1:0] o, input logic [31:0] d);
    memwriteM  = 1'b1;
    sbM        = 1'($urandom_range(0, 1));
    aluoutM    = BASE | {28'b0, o, 2'b00};
    writedataM = d;
    step();
    memwriteM  = 1'b0;
    aluoutM    = BASE + 32'd4;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Async reset mid-cycle: txd must go high without waiting for an edge
  task automatic do_reset();
    #1;
    reset = 1'b0;
    #1;
    chk("txd_async", {31'b0, txd}, 32'd1);
    chk("irq_async", {31'b0, irq}, 32'd0);
    chk("status_rst", rdata, 32'h0000_0002);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int r;
    reset = 1'b0; memwriteM = 1'b0; sbM = 1'b0;
    aluoutM = BASE + 32'd4; writedataM = '0;
    model_reset();
    #1;
    chk("rst_txd", {31'b0, txd}, 32'd1);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_status", rdata, 32'h0000_0002);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle(2);

    // Single frame of A5
    wr(2'd2, 32'h1);
    wr(2'd0, 32'hA5);
    idle(FL + 5);

    // Overflow with transmitter disabled, then clear via STATUS write
    wr(2'd2, 32'h0);
    for (int i = 0; i < 5; i++) wr(2'd0, 32'h10 + i);
    idle(2);
    wr(2'd1, 32'h0);
    idle(2);
    wr(2'd2, 32'h1);
    idle(4 * FL + 10);

    // Back-to-back frames
    wr(2'd0, 32'h01);
    wr(2'd0, 32'h02);
    idle(2 * FL + 5);

    // Reset during DATA
    wr(2'd0, 32'h5A);
    idle(3 * CPB);
    do_reset();
    idle(3);

    // Interrupt enable, byte 07
    wr(2'd2, 32'h3);
    wr(2'd0, 32'h07);
    idle(FL + 5);
    wr(2'd2, 32'h7);
    wr(2'd0, 32'h07);
    idle(FL + 5);

    // Randomized traffic
    repeat (400) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: wr(2'd0, $urandom);
        4: wr(2'd2, {$urandom_range(0, 15) == 0 ? 1'b0 : 1'b1, 31'h0} >> 31 |
                    ({29'($urandom), 3'b000} | {29'b0, 1'($urandom), 1'($urandom), 1'b0}));
        5: wr(2'd1, $urandom);
        6: wr(2'd3, $urandom);
        7: begin
          memwriteM  = 1'b1;
          aluoutM    = $urandom & 32'h7FFF_FFFF;
          writedataM = $urandom;
          step();
          memwriteM  = 1'b0;
          aluoutM    = BASE + 32'd4;
        end
        default: idle($urandom_range(1, 40));
      endcase
    end
    wr(2'd2, 32'h3);
    idle(DEPTH * FL + 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that responds to the pipelined CPU's data-memory store/load port in the M stage. It decodes a small register window, queues store-written bytes in a FIFO and serializes them 8N1 on `txd`. The top level muxes `rdata` onto `readdataM` whenever `sel` is high; otherwise data memory answers.

## Interface
- `BASE_ADDR`, 32'hFFFF_FF00: window base; bits [3:0] must be zero.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `memwriteM`  in  1  store strobe from the M stage.
- `sbM`  in  1  store-byte qualifier; accepted, and register writes behave identically to word stores.
- `aluoutM`  in  32  byte address.
- `writedataM`  in  32  store data.
- `sel`  out  1  combinational; high when `aluoutM[31:4] == BASE_ADDR[31:4]`.
- `rdata`  out  32  combinational read data for the addressed register.
- `txd`  out  1  serial line, idle high.
- `irq`  out  1  registered interrupt, level-sensitive.

## Operation
- Word offset is `aluoutM[3:2]`:
  - 0 TXDATA: write-only; reads return 0.
  - 1 STATUS: read-only; any write clears `ovf`.
  - 2 CTRL: R/W.
  - 3: reserved; reads 0, writes ignored.
- STATUS layout: [0] `busy` (FSM not IDLE), [1] `empty`, [2] `full`, [3] `ovf` (sticky), [15:8] FIFO count, other bits 0.
- CTRL layout: [0] `en`, [1] `irqen`; other bits read 0.
- TXDATA write (`sel & memwriteM`, offset 0) pushes `writedataM[7:0]`.
  - Push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `ovf` is set.
- FSM states and transitions:
  - IDLE → START when `en & !empty`; the FIFO pops into the shift register on that edge.
  - START → DATA after `CLKS_PER_BIT` cycles, `txd`=0.
  - DATA: 8 bits, LSB first, `CLKS_PER_BIT` cycles each.
  - DATA → STOP, `txd`=1 for `CLKS_PER_BIT` cycles.
  - STOP → IDLE, or directly START when `en & !empty` (back-to-back frames, no idle gap).
- A baud counter counts 0..CLKS_PER_BIT−1 and reloads on every state or bit advance. A 3-bit index tracks the data bit.
- Clearing `en` mid-frame: the current frame completes and no further pop occurs. FIFO contents are kept.
- `irq` is registered as `irqen & empty & !busy`.

## Timing
- Reset values: `txd`=1, `irq`=0, `en`=0, `irqen`=0, `ovf`=0, FIFO empty, FSM IDLE, baud counter 0. `sel` and `rdata` are combinational from the address.
- Reset is asynchronous. Asserting it mid-frame forces `txd` high immediately and discards the FIFO.
- Push latency: a byte written at edge k with `en`=1 and FSM IDLE causes the pop and `txd` fall at edge k+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles (11·CLKS_PER_BIT with parity).
- STATUS read in the same cycle as a TXDATA write shows the pre-write count.
- Simultaneous push and pop with FIFO full: both occur, count unchanged, `ovf` not set.
- Simultaneous push and pop with FIFO empty cannot occur, because pop requires `!empty` sampled before the edge.
- FIFO pointers wrap modulo `FIFO_DEPTH`. The count is held `$clog2(FIFO_DEPTH)+1` bits wide and zero-extended into [15:8].

## Configuration
- `UART_TX_PARITY_EN` defined:
  - Adds a PARITY state between DATA and STOP, driving even parity (`^data`) for `CLKS_PER_BIT` cycles.
  - Frame becomes 11 bits.
  - CTRL[2] `odd` selects odd parity (`~^data`).
- Undefined: no PARITY state, CTRL[2] reads 0, frame is 10 bits.

## Structure
- Package `mmio_uart_pkg` holds:
  - register offset constants (TXDATA=0, STATUS=1, CTRL=2);
  - STATUS/CTRL bit-position constants;
  - the `tx_state_t` enum (IDLE, START, DATA, PARITY, STOP).
- One sub-module, `sync_fifo`: parameterized width/depth; push/pop ports; full/empty/count outputs; asynchronous active-low reset.

## Test plan
Each scenario uses CLKS_PER_BIT=4 and FIFO_DEPTH=4 unless stated otherwise.

1. Reset, then read STATUS at BASE+4 → `rdata`=32'h0000_0002, `txd`=1, `irq`=0.
2. Write CTRL=1, then `sb` 8'hA5 to BASE+0 → `txd` falls one edge later and shows 0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit; `busy` is high for 40 cycles.
3. With `en`=0, write 5 bytes → STATUS count=4, `full`=1, `ovf`=1. Then write STATUS → `ovf`=0.
4. Write CTRL=1 and queue 8'h01, 8'h02 → two frames back-to-back with no idle high beyond the stop bit; 80 cycles total.
5. Assert reset during DATA of a frame → `txd`=1 asynchronously and the FIFO is empty after release.
6. Write CTRL=3 and send one byte → `irq` is low while busy and rises one cycle after STOP ends. With `UART_TX_PARITY_EN` and byte 8'h07, the parity bit is 1.
